// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR stream driver and its FIFO.
package fir_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } driver_state_t;

  // Cycles from the FIR input_ready pulse to its output_ready pulse.
  localparam int FIR_LATENCY = 18;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO, zero-latency head (pop_data shows the oldest entry).
// Pushes while full and pops while empty are ignored; full/empty come from a registered count.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge ck) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_driver.sv
// Paces buffered samples into the FIR pulse protocol and returns results on valid/ready.
// Head sample to m_valid is 21 cycles; m_ready low stalls the result in CAPTURE, then the FIFO fills and s_ready drops.
module fir_driver
  import fir_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] fir_in,
  output logic             fir_input_ready,
  input  logic [WIDTH-1:0] fir_out,
  input  logic             fir_output_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             timeout_err,
  input  logic             clear_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  driver_state_t    r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_fir_in;
  logic             r_input_ready;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_timeout_err;

  logic [WIDTH-1:0] w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_pop;

  assign s_ready = !w_fifo_full;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = (r_state == IDLE) && !w_fifo_empty;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck        (ck),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (s_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_fir_in      <= '0;
      r_input_ready <= 1'b0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_input_ready <= 1'b0;
      if (clear_err) begin
        r_timeout_err <= 1'b0;
      end
      if (m_ready) begin
        r_m_valid <= 1'b0;
      end
      // Later assignments below override the clears above: set/reload wins.
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_fir_in      <= w_fifo_head;
            r_input_ready <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (fir_output_ready) begin
            r_state <= CAPTURE;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        CAPTURE: begin
          // No new issue can start from here, so fir_out stays put while stalled.
          if (!r_m_valid || m_ready) begin
            r_m_data  <= fir_out;
            r_m_valid <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fir_in          = r_fir_in;
  assign fir_input_ready = r_input_ready;
  assign m_data          = r_m_data;
  assign m_valid         = r_m_valid;
  assign busy            = (r_state != IDLE);
  assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_fir_driver.sv
// Bench for fir_driver: behavioural 16-tap FIR responder plus an in-order result scoreboard.
module tb_fir_driver;
  import fir_pkg::*;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] fir_in;
  logic        fir_input_ready;
  logic [15:0] fir_out;
  logic        fir_output_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        timeout_err;
  logic        clear_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] sb[$];
  int          pulse_cyc[$];
  logic [15:0] mon_exp;

  always #5 ck = ~ck;

  fir_driver #(.WIDTH(16), .DEPTH(4), .TIMEOUT(31)) dut (
    .ck               (ck),
    .rst_n            (rst_n),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .fir_in           (fir_in),
    .fir_input_ready  (fir_input_ready),
    .fir_out          (fir_out),
    .fir_output_ready (fir_output_ready),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .clear_err        (clear_err)
  );

  // FIR model: Q15 coefficients, out = sum(c[k]*x[n-k]) >>> 15, truncated to 16 bits.
  int coef[16] = '{-82, 145, -210, 330, 512, -777, 1024, 1500,
                   1500, 1024, -777, 512, 330, -210, 145, -82};
  logic         fir_en = 1'b1;
  logic [255:0] fir_hist;
  logic [255:0] ref_hist = '0;
  int           fir_cnt;

  function automatic logic [15:0] fir_calc(input logic [255:0] h);
    longint acc = 0;
    for (int k = 0; k < 16; k++) begin
      acc += longint'(coef[k]) * longint'($signed(h[16*k +: 16]));
    end
    return 16'(acc >>> 15);
  endfunction

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      fir_hist         <= '0;
      fir_cnt          <= 0;
      fir_output_ready <= 1'b0;
      fir_out          <= '0;
    end else begin
      fir_output_ready <= 1'b0;
      if (fir_input_ready && fir_en) begin
        fir_hist <= {fir_hist[239:0], fir_in};
        fir_cnt  <= 1;
      end else if (fir_cnt == FIR_LATENCY - 1) begin
        fir_out          <= fir_calc(fir_hist);
        fir_output_ready <= 1'b1;
        fir_cnt          <= 0;
      end else if (fir_cnt != 0) begin
        fir_cnt <= fir_cnt + 1;
      end
    end
  end

  always @(posedge ck) cyc <= cyc + 1;

  always @(negedge ck) begin
    if (rst_n && fir_input_ready) pulse_cyc.push_back(cyc);
  end

  always @(negedge ck) begin
    if (rst_n && m_valid && m_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got m_data=%h, expected no result", m_data);
      end else begin
        mon_exp = sb.pop_front();
        if (m_data !== mon_exp) begin
          n_err++;
          $display("FAIL out_data: got %h, expected %h", m_data, mon_exp);
        end
      end
    end
  end

  task automatic expect_sample(input logic [15:0] x);
    ref_hist = {ref_hist[239:0], x};
    sb.push_back(fir_calc(ref_hist));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] x, input bit with_exp, output bit ok, output int waited);
    waited  = 0;
    s_data  = x;
    s_valid = 1'b1;
    @(negedge ck);
    while (!s_ready && waited < 200) begin
      @(posedge ck);
      #1;
      waited++;
      @(negedge ck);
    end
    ok = s_ready;
    if (ok && with_exp) expect_sample(x);
    @(posedge ck);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output int left);
    int w = 0;
    while ((sb.size() != 0 || busy) && w < budget) begin
      step(1);
      w++;
    end
    left = sb.size() + (busy ? 1 : 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; clear_err = 1'b0;
    ref_hist = '0;
    step(3);
    n_vec++;
    if ({s_ready, fir_input_ready, m_valid, busy, timeout_err} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/irdy/mv/busy/err=%b, expected 10000",
               {s_ready, fir_input_ready, m_valid, busy, timeout_err});
    end
    n_vec++;
    if (fir_in !== 16'h0000) begin
      n_err++; $display("FAIL reset_fir_in: got %h, expected 0000", fir_in);
    end
    n_vec++;
    if (m_data !== 16'h0000) begin
      n_err++; $display("FAIL reset_m_data: got %h, expected 0000", m_data);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single();
    s_data = 16'h4000; s_valid = 1'b1;
    expect_sample(16'h4000);
    step(1);
    s_valid = 1'b0;
    n_vec++;
    if (fir_input_ready !== 1'b0) begin
      n_err++; $display("FAIL single_irdy c=0: got %b, expected 0", fir_input_ready);
    end
    for (int c = 1; c <= 23; c++) begin
      step(1);
      n_vec++;
      if (fir_input_ready !== (c == 1)) begin
        n_err++; $display("FAIL single_irdy c=%0d: got %b, expected %b", c, fir_input_ready, (c == 1));
      end
      n_vec++;
      if (m_valid !== (c == 21)) begin
        n_err++; $display("FAIL single_mvalid c=%0d: got %b, expected %b", c, m_valid, (c == 21));
      end
      if (c == 21) begin
        n_vec++;
        if (m_data !== 16'hFFD7) begin
          n_err++; $display("FAIL single_data: got %h, expected ffd7", m_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp[6] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'hC000};
    int first_block = -1;
    int left;
    m_ready = 1'b1;
    pulse_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      bit ok;
      int w;
      push(smp[i], 1'b1, ok, w);
      n_vec++;
      if (ok !== 1'b1) begin
        n_err++; $display("FAIL burst_accept %0d: got %b, expected 1", i, ok);
      end
      if (w > 0 && first_block < 0) first_block = i;
    end
    n_vec++;
    if (first_block !== 5) begin
      n_err++; $display("FAIL burst_full_point: first blocked push %0d, expected 5", first_block);
    end
    wait_drain(400, left);
    n_vec++;
    if (left !== 0) begin
      n_err++; $display("FAIL burst_drain: %0d outstanding, expected 0", left);
    end
    n_vec++;
    if (pulse_cyc.size() !== 6) begin
      n_err++; $display("FAIL burst_pulses: got %0d, expected 6", pulse_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_vec++;
        if (pulse_cyc[i] - pulse_cyc[i-1] !== 21) begin
          n_err++; $display("FAIL burst_period %0d: got %0d, expected 21", i, pulse_cyc[i] - pulse_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    logic [15:0] held = '0;
    int left;
    m_ready = 1'b0;
    pulse_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      bit ok;
      int w;
      push(16'h0F00 + 16'(i * 16'h1111), 1'b1, ok, w);
      n_vec++;
      if (ok !== 1'b1) begin
        n_err++; $display("FAIL bp_accept %0d: got %b, expected 1", i, ok);
      end
    end
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (seen) begin
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          n_err++;
          $display("FAIL bp_hold %0d: got valid=%b data=%h, expected valid=1 data=%h", i, m_valid, m_data, held);
        end
      end else if (m_valid) begin
        seen = 1;
        held = sb[0];
        n_vec++;
        if (m_data !== held) begin
          n_err++; $display("FAIL bp_first: got %h, expected %h", m_data, held);
        end
      end
    end
    n_vec++;
    if (seen !== 1'b1) begin
      n_err++; $display("FAIL bp_valid: got no result, expected m_valid held");
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL bp_capture_stall: got busy=%b, expected 1", busy);
    end
    n_vec++;
    if (pulse_cyc.size() !== 2) begin
      n_err++; $display("FAIL bp_no_third_issue: got %0d pulses, expected 2", pulse_cyc.size());
    end
    m_ready = 1'b1;
    wait_drain(200, left);
    n_vec++;
    if (left !== 0) begin
      n_err++; $display("FAIL bp_drain: %0d outstanding, expected 0", left);
    end
    n_vec++;
    if (pulse_cyc.size() !== 3) begin
      n_err++; $display("FAIL bp_pulses: got %0d, expected 3", pulse_cyc.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int w;
    fir_en = 1'b0;
    push(16'h1111, 1'b0, ok, w);
    push(16'h2222, 1'b0, ok, w);
    w = 0;
    while (!fir_input_ready && w < 10) begin
      step(1);
      w++;
    end
    n_vec++;
    if (fir_input_ready !== 1'b1) begin
      n_err++; $display("FAIL to_issue: got irdy=%b, expected 1", fir_input_ready);
    end
    for (int c = 1; c <= 34; c++) begin
      step(1);
      if (c == 32) begin
        n_vec++;
        if (timeout_err !== 1'b0) begin
          n_err++; $display("FAIL to_early: got err=%b at +32, expected 0", timeout_err);
        end
      end
      if (c == 33) begin
        n_vec++;
        if ({timeout_err, busy} !== 2'b10) begin
          n_err++; $display("FAIL to_fire: got err/busy=%b at +33, expected 10", {timeout_err, busy});
        end
      end
      if (c == 34) begin
        n_vec++;
        if (fir_input_ready !== 1'b1) begin
          n_err++; $display("FAIL to_next_issue: got irdy=%b, expected 1", fir_input_ready);
        end
      end
    end
    for (int c = 1; c <= 33; c++) begin
      step(1);
      if (c == 5 || c == 32) clear_err = 1'b1;
      if (c == 6 || c == 33) clear_err = 1'b0;
      if (c == 6) begin
        n_vec++;
        if (timeout_err !== 1'b0) begin
          n_err++; $display("FAIL to_clear: got err=%b, expected 0", timeout_err);
        end
      end
      if (c == 33) begin
        n_vec++;
        if (timeout_err !== 1'b1) begin
          n_err++; $display("FAIL to_set_wins: got err=%b, expected 1", timeout_err);
        end
      end
    end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    fir_en = 1'b1;
    step(2);
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int w;
    int act = 0;
    m_ready = 1'b1;
    pulse_cyc.delete();
    push(16'h5A5A, 1'b0, ok, w);
    push(16'h0123, 1'b0, ok, w);
    push(16'h4567, 1'b0, ok, w);
    n_vec++;
    if (pulse_cyc.size() !== 1) begin
      n_err++; $display("FAIL rst_issue: got %0d pulses, expected 1", pulse_cyc.size());
    end else begin
      w = 0;
      while (cyc < pulse_cyc[0] + 9 && w < 50) begin
        step(1);
        w++;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_ready, fir_input_ready, m_valid, busy, timeout_err} !== 5'b10000) begin
      n_err++;
      $display("FAIL rst_mid_flags: got rdy/irdy/mv/busy/err=%b, expected 10000",
               {s_ready, fir_input_ready, m_valid, busy, timeout_err});
    end
    n_vec++;
    if ({fir_in, m_data} !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_data: got fir_in=%h m_data=%h, expected 0000 0000", fir_in, m_data);
    end
    step(1);
    rst_n = 1'b1;
    ref_hist = '0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (m_valid || fir_input_ready || !s_ready) act++;
    end
    n_vec++;
    if (act !== 0) begin
      n_err++; $display("FAIL rst_mid_quiet: got %0d active cycles, expected 0", act);
    end
  endtask

  task automatic test_fifo_wrap();
    bit done = 0;
    int guard = 0;
    int left;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bit ok;
          int w;
          step($urandom_range(0, 3));
          push(16'($urandom), 1'b1, ok, w);
          n_vec++;
          if (ok !== 1'b1) begin
            n_err++; $display("FAIL wrap_accept %0d: got %b, expected 1", i, ok);
          end
        end
        done = 1;
      end
      begin
        while (!(done && sb.size() == 0) && guard < 4000) begin
          step(1);
          m_ready = 1'($urandom_range(0, 1));
          guard++;
        end
      end
    join
    m_ready = 1'b1;
    wait_drain(200, left);
    n_vec++;
    if (left !== 0) begin
      n_err++; $display("FAIL wrap_drain: %0d outstanding, expected 0", left);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_fifo_wrap();
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_driver.md
# fir_driver

Stream-side companion to the team's 16-tap FIR filter. It accepts samples from an upstream valid/ready source, buffers them in a small FIFO, and paces them into the FIR's one-cycle `input_ready` pulse protocol. It then waits for the FIR's `output_ready` pulse, captures the filtered result, and presents it downstream on a valid/ready interface with back-pressure. It sits between the sample source (ADC/test stimulus) and the sink, wrapping the FIR instance at the top level.

## Interface

Parameters:
- `WIDTH`, 16: sample width; must match the FIR sample width.
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `TIMEOUT`, 31: maximum WAIT cycles for FIR `output_ready`; must be ≥19.

Ports:
- `ck` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `s_data` in WIDTH: upstream sample.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: FIFO not full.
- `fir_in` out WIDTH: sample to the FIR `in`.
- `fir_input_ready` out 1: one-cycle start pulse to the FIR.
- `fir_out` in WIDTH: FIR `out`.
- `fir_output_ready` in 1: FIR completion pulse.
- `m_data` out WIDTH: filtered result.
- `m_valid` out 1: result valid.
- `m_ready` in 1: downstream accept.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: sticky timeout flag.
- `clear_err` in 1: synchronous clear of `timeout_err`.

## Operation

- **Upstream handshake:** push when `s_valid && s_ready`. `s_ready = !full`, where `full` is derived from the registered count.
- **FSM states:** IDLE, ISSUE, WAIT, CAPTURE.
- **IDLE:**
  - If the FIFO is not empty: pop the head into the `fir_in` register, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:** `fir_input_ready = 1` for exactly this cycle. Clear the timeout counter, go to WAIT.
- **WAIT:**
  - On `fir_output_ready`: go to CAPTURE.
  - Else, when the counter reaches `TIMEOUT`: set `timeout_err`, drop the sample, go to IDLE.
  - Else: increment the counter.
- **CAPTURE:** `fir_out` is valid here.
  - If `!m_valid || m_ready`: load `m_data <= fir_out`, set `m_valid`, go to IDLE.
  - Otherwise stall in CAPTURE. The FIR output register is stable because no new issue is possible.
- **`fir_in` hold:** `fir_in` is held constant from the pop until the next pop. The FIR samples it one cycle after the pulse.
- **Output handshake:** `m_valid` clears on `m_ready` unless it is reloaded in the same cycle.
- **`timeout_err` priority:** `clear_err` and a timeout in the same cycle leave the flag set (set wins).
- **FIFO boundaries:**
  - Push while full is impossible (`s_ready` is low).
  - Pop only when not empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- **Data path:** no arithmetic on data; samples pass through bit-exact.

## Timing

- **Reset values (asynchronous, on `rst_n` low):**
  - `s_ready` = 1 (FIFO empty after reset).
  - `fir_in` = 0, `fir_input_ready` = 0.
  - `m_data` = 0, `m_valid` = 0.
  - `busy` = 0, `timeout_err` = 0.
  - State IDLE; FIFO emptied; counter = 0.
- **Cycle timeline:** IDLE pop at cycle T.
  - T+1: `fir_input_ready` = 1.
  - T+2: FIR loading.
  - T+3..T+18: FIR processing.
  - T+19: `fir_output_ready`.
  - T+20: CAPTURE.
  - T+21: `m_valid` = 1, back in IDLE.
- **Throughput and latency:** minimum issue period is 21 cycles. Latency from an FIFO-head sample to `m_valid` is 21 cycles with no stall.
- **Timeout:** fires after `TIMEOUT`+1 WAIT cycles with no `fir_output_ready`.
- **Reset mid-operation:** an in-flight sample is lost; no `m_valid` is produced for it. The FIR reset is driven from `!rst_n` at the top level.

## Structure

- **Shared package `fir_pkg`:**
  - `sample_t` (`logic signed [15:0]`).
  - `driver_state_t` enum {IDLE, ISSUE, WAIT, CAPTURE}.
  - Constant `FIR_LATENCY = 18` (input pulse to output pulse).
- **Sub-module `sample_fifo`:** parameterised `WIDTH`/`DEPTH`, with push/pop/full/empty/count and asynchronous active-low reset. Instantiated once.
- **`fir_driver`:** FSM, timeout counter, `fir_in` register, output register.

## Test plan

1. **Single sample.**
   - Stimulus: FIR history flushed with 16 zeros, push 16'h4000.
   - Required: `fir_input_ready` high exactly one cycle at T+1; `m_valid` at T+21 with `m_data` = 16'hFFD7 (−41).
2. **Burst with `m_ready` = 1.**
   - Stimulus: push 6 samples back-to-back.
   - Required: `s_ready` drops once the FIFO holds 4 entries; all 6 are accepted eventually; `fir_input_ready` pulses exactly 21 cycles apart; results are in order.
3. **Back-pressure.**
   - Stimulus: `m_ready` = 0 for 100 cycles with 3 samples queued.
   - Required:
     - First result held with `m_data` unchanged.
     - Second result stalls in CAPTURE; no third `fir_input_ready`.
     - After release, 3 results arrive in order with none lost.
4. **Timeout.**
   - Stimulus: FIR model never asserts `output_ready`.
   - Required: `timeout_err` set 32 cycles after entering WAIT; next sample issued.
   - Then: `clear_err` clears the flag. A `clear_err` coincident with a new timeout leaves it set.
5. **Reset mid-WAIT.**
   - Stimulus: drop `rst_n` at T+10.
   - Required: all outputs take their reset values immediately; the FIFO is empty; no `m_valid` follows.
6. **FIFO wrap.**
   - Stimulus: 20 samples with random `s_valid` and `m_ready` gaps.
   - Required: the output sequence matches a reference FIR model bit-exact.
